// File: rtl/lane_step_scheduler.sv
// Movement timebase: turns a tap bit of the free-running amount counter into base ticks,
// then divides those ticks into one step-enable pulse per lane at a level-adjusted period.
module lane_step_scheduler #(
    parameter int LANES   = 4,
    parameter int AW      = 32,
    parameter int TAP_BIT = 21,
    parameter int PW      = 4,
    parameter int LW      = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [AW-1:0]         amount,
    input  logic                  pause,
    input  logic                  restart,
    input  logic                  level_up,
    input  logic [LANES*PW-1:0]   lane_period,
    output logic [LANES-1:0]      lane_step,
    output logic [LW-1:0]         level,
    output logic [15:0]           tick_count
);

    localparam int EW = ((PW > LW) ? PW : LW) + 1;

    logic                tap_hist;
    logic                base_tick;
    logic [PW-1:0]       cnt        [LANES];
    logic [PW-1:0]       reload     [LANES];
    logic [EW-1:0]       period_ext [LANES];
    logic [EW-1:0]       diff       [LANES];
    logic [EW-1:0]       level_ext;
    logic [LANES-1:0]    frozen;

    assign base_tick = amount[TAP_BIT] & ~tap_hist & ~pause & ~restart;
    assign level_ext = EW'(level);

    // Reload value is eff-1, where eff = period - level clamped to at least 1.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            period_ext[i] = EW'(lane_period[i*PW +: PW]);
            frozen[i]     = (lane_period[i*PW +: PW] == '0);
            diff[i]       = period_ext[i] - level_ext;
            reload[i]     = '0;
            if (period_ext[i] > level_ext) begin
                reload[i] = PW'(diff[i] - EW'(1));
            end
        end
    end

    // The tap history keeps sampling while paused so that releasing pause cannot
    // turn a long-high tap bit into a fresh rising edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tap_hist   <= 1'b1;
            lane_step  <= '0;
            level      <= '0;
            tick_count <= '0;
            for (int i = 0; i < LANES; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            tap_hist <= amount[TAP_BIT];
            if (restart) begin
                lane_step  <= '0;
                level      <= '0;
                tick_count <= '0;
                for (int i = 0; i < LANES; i++) begin
                    cnt[i] <= '0;
                end
            end else begin
                if (level_up && (level != {LW{1'b1}})) begin
                    level <= level + LW'(1);
                end
                if (base_tick) begin
                    tick_count <= tick_count + 16'd1;
                end
                // A frozen lane is pinned to zero so it steps on the first tick once re-enabled.
                for (int i = 0; i < LANES; i++) begin
                    lane_step[i] <= 1'b0;
                    if (frozen[i]) begin
                        cnt[i] <= '0;
                    end else if (base_tick) begin
                        if (cnt[i] == '0) begin
                            lane_step[i] <= 1'b1;
                            cnt[i]       <= reload[i];
                        end else begin
                            cnt[i] <= cnt[i] - PW'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_step_scheduler.sv
// Directed bench for lane_step_scheduler with TAP_BIT=2, so a base tick arrives every 8 clocks.
module tb_lane_step_scheduler;

    localparam int LANES = 4;
    localparam int AW    = 32;
    localparam int PW    = 4;
    localparam int LW    = 3;

    logic                clock;
    logic                reset;
    logic [AW-1:0]       amount;
    logic                pause;
    logic                restart;
    logic                level_up;
    logic [LANES*PW-1:0] lane_period;
    logic [LANES-1:0]    lane_step;
    logic [LW-1:0]       level;
    logic [15:0]         tick_count;

    int checkCount;
    int failCount;
    int pulseCount [LANES];

    lane_step_scheduler #(
        .LANES(LANES), .AW(AW), .TAP_BIT(2), .PW(PW), .LW(LW)
    ) dut (
        .clock(clock), .reset(reset), .amount(amount), .pause(pause),
        .restart(restart), .level_up(level_up), .lane_period(lane_period),
        .lane_step(lane_step), .level(level), .tick_count(tick_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Each cycle: wait past the edge, tally pulses, then present the next amount.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < LANES; i++) begin
                pulseCount[i] += int'(lane_step[i]);
            end
            amount = amount + 1;
        end
    endtask

    task automatic clearCounts();
        for (int i = 0; i < LANES; i++) begin
            pulseCount[i] = 0;
        end
    endtask

    task automatic applyReset(input logic [AW-1:0] startAmount);
        reset    = 1'b0;
        amount   = startAmount;
        pause    = 1'b0;
        restart  = 1'b0;
        level_up = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        clearCounts();
    endtask

    initial begin
        checkCount  = 0;
        failCount   = 0;
        lane_period = 16'h0321;
        clearCounts();

        // Basic stepping at level 0
        applyReset(0);
        checkOutput("reset_step", 32'(lane_step), 32'h0);
        checkOutput("reset_level", 32'(level), 32'h0);
        checkOutput("reset_ticks", 32'(tick_count), 32'h0);
        applyStimulus(4);
        checkOutput("no_early_pulse", 32'(pulseCount[0] + pulseCount[1] + pulseCount[2]), 32'h0);
        applyStimulus(1);
        checkOutput("first_tick_step", 32'(lane_step), 32'h7);
        checkOutput("first_tick_count", 32'(tick_count), 32'h1);
        applyStimulus(72);
        checkOutput("ten_ticks", 32'(tick_count), 32'd10);
        checkOutput("lane0_pulses", 32'(pulseCount[0]), 32'd10);
        checkOutput("lane1_pulses", 32'(pulseCount[1]), 32'd5);
        checkOutput("lane2_pulses", 32'(pulseCount[2]), 32'd4);
        checkOutput("lane3_pulses", 32'(pulseCount[3]), 32'd0);
        checkOutput("tick10_step", 32'(lane_step), 32'h5);
        applyStimulus(1);
        checkOutput("step_one_cycle", 32'(lane_step), 32'h0);

        // Difficulty: level 3 clamps every lane to one step per tick
        applyReset(0);
        level_up = 1'b1;
        applyStimulus(3);
        level_up = 1'b0;
        checkOutput("level_three", 32'(level), 32'd3);
        applyStimulus(2);
        checkOutput("lvl_first_step", 32'(lane_step), 32'h7);
        applyStimulus(72);
        checkOutput("lvl_lane0", 32'(pulseCount[0]), 32'd10);
        checkOutput("lvl_lane1", 32'(pulseCount[1]), 32'd10);
        checkOutput("lvl_lane2", 32'(pulseCount[2]), 32'd10);
        checkOutput("lvl_lane3", 32'(pulseCount[3]), 32'd0);
        level_up = 1'b1;
        applyStimulus(9);
        level_up = 1'b0;
        checkOutput("level_saturate", 32'(level), 32'd7);

        // Pause for 40 clocks, then no catch-up burst
        applyReset(0);
        applyStimulus(5);
        checkOutput("pre_pause_step", 32'(lane_step), 32'h7);
        clearCounts();
        pause = 1'b1;
        applyStimulus(40);
        pause = 1'b0;
        checkOutput("pause_pulses", 32'(pulseCount[0] + pulseCount[1] + pulseCount[2]), 32'h0);
        checkOutput("pause_ticks", 32'(tick_count), 32'd1);
        applyStimulus(7);
        checkOutput("no_burst", 32'(pulseCount[0] + pulseCount[1] + pulseCount[2]), 32'h0);
        checkOutput("no_burst_ticks", 32'(tick_count), 32'd1);
        applyStimulus(1);
        checkOutput("post_pause_step", 32'(lane_step), 32'h1);
        checkOutput("post_pause_ticks", 32'(tick_count), 32'd2);

        // Restart collides with a base tick and level_up
        level_up = 1'b1;
        applyStimulus(1);
        level_up = 1'b0;
        checkOutput("level_one", 32'(level), 32'd1);
        applyStimulus(6);
        restart  = 1'b1;
        level_up = 1'b1;
        applyStimulus(1);
        restart  = 1'b0;
        level_up = 1'b0;
        checkOutput("restart_step", 32'(lane_step), 32'h0);
        checkOutput("restart_level", 32'(level), 32'h0);
        checkOutput("restart_ticks", 32'(tick_count), 32'h0);
        clearCounts();
        applyStimulus(7);
        checkOutput("restart_quiet", 32'(pulseCount[0] + pulseCount[1] + pulseCount[2]), 32'h0);
        applyStimulus(1);
        checkOutput("restart_resume", 32'(lane_step), 32'h7);
        checkOutput("restart_resume_t", 32'(tick_count), 32'd1);

        // Reset released with the tap bit already high
        applyReset(4);
        applyStimulus(8);
        checkOutput("tap_high_quiet", 32'(pulseCount[0] + pulseCount[1] + pulseCount[2]), 32'h0);
        checkOutput("tap_high_ticks", 32'(tick_count), 32'h0);
        applyStimulus(1);
        checkOutput("tap_rise_step", 32'(lane_step), 32'h7);
        reset = 1'b0;
        #1;
        checkOutput("async_clear", 32'(lane_step), 32'h0);
        checkOutput("async_ticks", 32'(tick_count), 32'h0);

        // Freeze lane1 mid-count, then restore it
        applyReset(0);
        applyStimulus(5);
        checkOutput("freeze_first", 32'(lane_step), 32'h7);
        clearCounts();
        lane_period = 16'h0301;
        applyStimulus(8);
        checkOutput("frozen_lane1", 32'(pulseCount[1]), 32'd0);
        checkOutput("frozen_lane0", 32'(pulseCount[0]), 32'd1);
        lane_period = 16'h0321;
        clearCounts();
        applyStimulus(8);
        checkOutput("thaw_lane1", 32'(pulseCount[1]), 32'd1);
        checkOutput("thaw_step", 32'(lane_step), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/lane_step_scheduler.md
Name: lane_step_scheduler

Overview:
- Consumes the free-running `amount` count from the clock counter and turns it into the game's movement timebase.
- Extracts a base tick from one tap bit of `amount`.
- Derives one single-cycle step-enable pulse per traffic/log lane, each at its own programmable period.
- Period shortens with difficulty level; global pause and restart are supported. Lane movement logic downstream consumes `lane_step`.

Parameters:
- LANES, 4, number of independent lanes.
- AW, 32, width of `amount` input.
- TAP_BIT, 21, bit of `amount` whose rising edge is the base tick (bench overrides to 2).
- PW, 4, width of each lane period field.
- LW, 3, level width; level saturates at 2^LW-1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- amount  in  AW  free-running count from clock counter.
- pause  in  1  level; suppresses base ticks while high.
- restart  in  1  sync pulse; clears lane counters, level, tick count.
- level_up  in  1  sync pulse; raise difficulty by one.
- lane_period  in  LANES*PW  base period per lane in base ticks; lane i at [i*PW +: PW]; 0 = lane frozen.
- lane_step  out  LANES  one-cycle step enable per lane.
- level  out  LW  current difficulty.
- tick_count  out  16  base ticks elapsed since reset/restart.

Behaviour:
- Reset (reset low, async) sets these values:
  - lane_step=0, level=0, tick_count=0, all lane counters=0.
  - Tap history register=1, so no spurious tick if the tap bit is already 1 at release.
- Tap history register samples amount[TAP_BIT] every clock, including while paused, so releasing pause never produces a burst.
- Base tick (combinational, edge k):
  - base_tick = amount[TAP_BIT] & ~tap_hist & ~pause & ~restart.
- Effective period per lane:
  - eff_i = lane_period_i - level, clamped to a minimum of 1.
  - If lane_period_i = 0, the lane is frozen: counter held 0, never steps.
  - Arithmetic is done in max(PW,LW)+1 bits to avoid wrap.
- Lane counter update on base_tick (non-frozen lane i):
  - cnt_i==0: lane_step[i]=1 in the cycle after edge k; cnt_i <= eff_i-1.
  - otherwise: cnt_i <= cnt_i-1; lane_step[i]=0.
- lane_step is registered and high for exactly one clock per firing; it is 0 in every cycle without a base tick.
- Latency: one clock from the base tick edge to lane_step.
- After reset/restart, every enabled lane steps on the first base tick (counter starts at 0).
- Level changes:
  - Take effect at the next reload only; counters in flight are not truncated.
  - A counter above the new eff-1 counts down normally.
- level_up: level <= level+1, saturating at 2^LW-1 (7 stays 7).
- restart has priority over level_up and base tick in the same cycle:
  - counters=0, level=0, tick_count=0, lane_step=0 next cycle.
- tick_count increments on each base_tick and wraps 0xFFFF->0.
- pause high: no base ticks; counters, level and tick_count are held. level_up is still honoured while paused.
- Period change while running: picked up at the next reload of that lane. A lane changed to 0 freezes immediately with its counter forced to 0.
- Asserting reset mid-count clears everything asynchronously; no pulse is emitted in that cycle.

Test Plan:
- TAP_BIT=2, amount++ each clock from 0, periods {0,3,2,1} (lane3..0), level 0.
  - The first tick occurs when amount goes 3->4; lanes 0,1,2 all pulse one cycle later; lane3 never pulses.
  - Thereafter lane0 pulses every 8 clocks, lane1 every 16, lane2 every 24; tick_count=10 after 10 ticks.
- Same setup, three level_up pulses before the first tick.
  - Lane2 (base 3) eff=1 pulses every 8 clocks; lane1 eff=1; level=3.
  - Nine more level_up pulses: level holds at 7.
- Pause asserted for 40 clocks with amount still incrementing.
  - Zero lane_step pulses and tick_count frozen during the pause.
  - After release, the first pulse comes only at the next genuine 3->4-style tap rising edge; no catch-up burst.
- restart asserted in the same cycle as a base tick and level_up.
  - No lane_step the next cycle; level=0, tick_count=0; all lanes pulse on the following tick.
- Reset released with amount=4 (tap bit already 1): no tick until the tap bit falls and rises again (amount 12).
  - Pulling reset low mid-count clears lane_step the same cycle, asynchronously.
- Change lane1 period from 2 to 0 mid-count: lane1 stops immediately.
  - Restoring the period to 2: lane1 pulses on the next tick (counter was 0).
